aclint_mtimer: RTL and testbench

ACLINT_MTIMER -- requirements
Module: aclint_mtimer

---
 rtl/aclint_mtimer.sv | 210 +++++++++++++++++++++
 tb/tb_aclint_mtimer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclint_mtimer.sv
// RISC-V ACLINT machine timer with per-hart mtimecmp/MSIP, a 64-bit mtime
// driven either by a synchronised rtc_i or by an internal prescaler.
module aclint_mtimer #(
    parameter int NR_HARTS    = 4,
    parameter int PRESCALE_W  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rtc_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [15:0]         addr_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          be_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic [NR_HARTS-1:0] timer_irq_o,
    output logic [NR_HARTS-1:0] ipi_o
);

    localparam logic [12:0]           HARTS    = 13'(NR_HARTS);
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [63:0]            r_mtime;
    logic [63:0]            r_cmp [NR_HARTS];
    logic [NR_HARTS-1:0]    r_msip;
    logic [NR_HARTS-1:0]    r_irq;
    logic [31:0]            r_shadow;
    logic                   r_en;
    logic                   r_src;
    logic [PRESCALE_W-1:0]  r_prescale;
    logic [PRESCALE_W-1:0]  r_pcnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rtc_d;
    logic                   r_rvalid;
    logic                   r_err;
    logic [31:0]            r_rdata;

    logic [15:0] w_addr;
    logic [15:0] w_cmp_off;
    logic [11:0] w_msip_idx;
    logic [12:0] w_cmp_idx;
    logic        w_is_msip, w_is_cmp, w_is_mtlo, w_is_mthi, w_is_ctrl, w_is_pre;
    logic        w_hit, w_wr, w_rd;
    logic        w_rtc_rise, w_pre_hit, w_tick;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr     = {addr_i[15:2], 2'b00};
    assign w_msip_idx = w_addr[13:2];
    assign w_cmp_off  = w_addr - 16'h4000;
    assign w_cmp_idx  = w_cmp_off[15:3];
    assign w_unused   = ^{addr_i[1:0], w_cmp_off[2:0]};

    assign w_is_msip = (w_addr < 16'h4000) && ({1'b0, w_msip_idx} < HARTS);
    assign w_is_cmp  = (w_addr >= 16'h4000) && (w_addr < 16'hBFF8) && (w_cmp_idx < HARTS);
    assign w_is_mtlo = (w_addr == 16'hBFF8);
    assign w_is_mthi = (w_addr == 16'hBFFC);
    assign w_is_ctrl = (w_addr == 16'hC000);
    assign w_is_pre  = (w_addr == 16'hC004);
    assign w_hit     = w_is_msip | w_is_cmp | w_is_mtlo | w_is_mthi | w_is_ctrl | w_is_pre;
    assign w_wr      = req_i & we_i & w_hit;
    assign w_rd      = req_i & ~we_i & w_hit;

    // Tick is judged from register state only, so a same-cycle CTRL write takes effect next cycle.
    assign w_rtc_rise = r_sync[SYNC_STAGES-1] & ~r_rtc_d;
    assign w_pre_hit  = (r_pcnt == r_prescale);
    assign w_tick     = r_en & (r_src ? w_pre_hit : w_rtc_rise);

    // Read data multiplexer.
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_msip) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                w_rdata = (w_msip_idx == 12'(h)) ? {31'h0, r_msip[h]} : w_rdata;
            end
        end else if (w_is_cmp) begin
            for (int h = 0; h < NR_HARTS; h++) begin
                w_rdata = (w_cmp_idx != 13'(h)) ? w_rdata :
                          (w_addr[2] ? r_cmp[h][63:32] : r_cmp[h][31:0]);
            end
        end else if (w_is_mtlo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_is_mthi) begin
            w_rdata = r_shadow;
        end else if (w_is_ctrl) begin
            w_rdata = {30'h0, r_src, r_en};
        end else if (w_is_pre) begin
            w_rdata = 32'(r_prescale);
        end else begin
            w_rdata = 32'h0;
        end
    end

    // Register file, mtime counter, read shadow and prescaler.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtime    <= 64'h0;
            for (int h = 0; h < NR_HARTS; h++) begin
                r_cmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
            r_msip     <= {NR_HARTS{1'b0}};
            r_shadow   <= 32'h0;
            r_en       <= 1'b1;
            r_src      <= 1'b0;
            r_prescale <= {PRESCALE_W{1'b0}};
            r_pcnt     <= {PRESCALE_W{1'b0}};
        end else begin
            for (int h = 0; h < NR_HARTS; h++) begin
                if (w_wr && w_is_msip && be_i[0] && (w_msip_idx == 12'(h))) begin
                    r_msip[h] <= wdata_i[0];
                end
                if (w_wr && w_is_cmp && (w_cmp_idx == 13'(h))) begin
                    if (w_addr[2]) begin
                        r_cmp[h][63:32] <= merge_be(r_cmp[h][63:32], wdata_i, be_i);
                    end else begin
                        r_cmp[h][31:0] <= merge_be(r_cmp[h][31:0], wdata_i, be_i);
                    end
                end
            end

            // A bus write to mtime wins over a coincident tick.
            if (w_wr && w_is_mtlo) begin
                r_mtime[31:0] <= merge_be(r_mtime[31:0], wdata_i, be_i);
            end else if (w_wr && w_is_mthi) begin
                r_mtime[63:32] <= merge_be(r_mtime[63:32], wdata_i, be_i);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'h1;
            end

            if (w_rd && w_is_mtlo) begin
                r_shadow <= r_mtime[63:32];
            end
            if (w_wr && w_is_ctrl && be_i[0]) begin
                r_en  <= wdata_i[0];
                r_src <= wdata_i[1];
            end
            if (w_wr && w_is_pre) begin
                r_prescale <= PRESCALE_W'(merge_be(32'(r_prescale), wdata_i, be_i));
            end

            if (w_wr && (w_is_ctrl || w_is_pre)) begin
                r_pcnt <= {PRESCALE_W{1'b0}};
            end else if (!r_src || w_pre_hit) begin
                r_pcnt <= {PRESCALE_W{1'b0}};
            end else begin
                r_pcnt <= r_pcnt + PCNT_ONE;
            end
        end
    end

    // rtc_i synchroniser and rising-edge detect flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_rtc_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rtc_i};
            r_rtc_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // Timer interrupts compare the previous cycle's register values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= {NR_HARTS{1'b0}};
        end else begin
            for (int h = 0; h < NR_HARTS; h++) begin
                r_irq[h] <= (r_mtime >= r_cmp[h]);
            end
        end
    end

    // Access response, one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_err    <= req_i & ~w_hit;
            r_rdata  <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign timer_irq_o = r_irq;
    assign ipi_o       = r_msip;

endmodule

// File: tb/tb_aclint_mtimer.sv
// Randomised bench for aclint_mtimer: a per-cycle behavioural model plus
// directed scenarios whose expected values are written out by hand.
`timescale 1ns/1ps
module tb_aclint_mtimer;
    localparam int NH = 2;
    localparam int PW = 16;
    localparam int SS = 2;
    localparam int K_ERR = 0, K_MSIP = 1, K_CMP = 2, K_MTLO = 3, K_MTHI = 4, K_CTRL = 5, K_PRE = 6;

    logic          clk = 1'b0;
    logic          rst, rtc, req, we;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          rvalid, err;
    logic [31:0]   rdata;
    logic [NH-1:0] irq, ipi;

    always #5 clk = ~clk;

    aclint_mtimer #(.NR_HARTS(NH), .PRESCALE_W(PW), .SYNC_STAGES(SS)) dut (
        .clk_i(clk), .rst_i(rst), .rtc_i(rtc), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .timer_irq_o(irq), .ipi_o(ipi)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]     m_mtime;
    logic [63:0]     m_cmp [NH];
    logic [NH-1:0]   m_msip, m_irq;
    logic [31:0]     m_shadow, m_rdata;
    logic            m_en, m_src, m_rvalid, m_err;
    int unsigned     m_pre;
    longint unsigned m_ncyc;
    bit              m_hist [SS+1];
    bit              m_last_tick;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic int kind_of(input int a, output int hart, output bit hi);
        int w;
        w = a - (a % 4);
        hart = 0;
        hi = 1'b0;
        if (w < 'h4000) begin
            hart = w / 4;
            return (hart < NH) ? K_MSIP : K_ERR;
        end
        if (w < 'hBFF8) begin
            hart = (w - 'h4000) / 8;
            hi = (((w - 'h4000) % 8) == 4);
            return (hart < NH) ? K_CMP : K_ERR;
        end
        case (w)
            'hBFF8:  return K_MTLO;
            'hBFFC:  return K_MTHI;
            'hC000:  return K_CTRL;
            'hC004:  return K_PRE;
            default: return K_ERR;
        endcase
    endfunction

    task automatic model_step();
        int kind, hart;
        bit hi, tick, mt_wr, clr, src_old;
        logic [NH-1:0] irq_n;
        if (rst) begin
            m_mtime = 64'h0;
            foreach (m_cmp[h]) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip = '0; m_shadow = 32'h0; m_en = 1'b1; m_src = 1'b0; m_pre = 0; m_ncyc = 0;
            foreach (m_hist[k]) m_hist[k] = 1'b0;
            m_rvalid = 1'b0; m_rdata = 32'h0; m_err = 1'b0; m_irq = '0; m_last_tick = 1'b0;
            return;
        end
        src_old = m_src;
        tick = m_en && (m_src ? ((m_ncyc % (64'(m_pre) + 64'd1)) == 64'(m_pre))
                              : (m_hist[SS-1] && !m_hist[SS]));
        for (int h = 0; h < NH; h++) irq_n[h] = (m_mtime >= m_cmp[h]);
        m_rvalid = req; m_rdata = 32'h0; m_err = 1'b0; mt_wr = 1'b0; clr = 1'b0;
        if (req) begin
            kind = kind_of(int'(addr), hart, hi);
            if (kind == K_ERR) begin
                m_err = 1'b1;
            end else if (!we) begin
                case (kind)
                    K_MSIP: m_rdata = {31'h0, m_msip[hart]};
                    K_CMP:  m_rdata = hi ? m_cmp[hart][63:32] : m_cmp[hart][31:0];
                    K_MTLO: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                    K_MTHI: m_rdata = m_shadow;
                    K_CTRL: m_rdata = {30'h0, m_src, m_en};
                    default: m_rdata = m_pre;
                endcase
            end else begin
                case (kind)
                    K_MSIP: if (be[0]) m_msip[hart] = wdata[0];
                    K_CMP:  if (hi) m_cmp[hart][63:32] = bmerge(m_cmp[hart][63:32], wdata, be);
                            else    m_cmp[hart][31:0]  = bmerge(m_cmp[hart][31:0], wdata, be);
                    K_MTLO: begin m_mtime[31:0]  = bmerge(m_mtime[31:0], wdata, be);  mt_wr = 1'b1; end
                    K_MTHI: begin m_mtime[63:32] = bmerge(m_mtime[63:32], wdata, be); mt_wr = 1'b1; end
                    K_CTRL: begin if (be[0]) {m_src, m_en} = wdata[1:0]; clr = 1'b1; end
                    default: begin m_pre = bmerge(m_pre, wdata, be) & 32'h0000_FFFF; clr = 1'b1; end
                endcase
            end
        end
        if (tick && !mt_wr) m_mtime = m_mtime + 64'd1;
        m_ncyc = (clr || !src_old) ? 64'd0 : m_ncyc + 64'd1;
        for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = rtc;
        m_irq = irq_n;
        m_last_tick = tick;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("rvalid", rvalid, m_rvalid);
            if (m_rvalid) begin
                chk("rdata", rdata, m_rdata);
                chk("err", err, m_err);
            end
            chk("timer_irq", irq, m_irq);
            chk("ipi", ipi, m_msip);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd_o, output logic er_o);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        rd_o = rdata; er_o = err;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] dd; logic ee;
        xfer(1'b1, a, d, b, dd, ee);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] dd; logic ee;
        xfer(1'b0, a, 32'h0, 4'h0, dd, ee);
        chk(name, dd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] addr_tab [18] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h4000, 16'h4004,
                                   16'h4008, 16'h400C, 16'h4010, 16'h4014, 16'hBFF8, 16'hBFFC,
                                   16'hC000, 16'hC004, 16'hC008, 16'hBFF0, 16'h3FFC, 16'hBFF8};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dd;
        logic        ee;
        rst = 1'b1; rtc = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 32'h0; be = 4'h0;
        idle(3);
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        xfer(1'b0, 16'h4000, 32'h0, 4'h0, dd, ee);
        chk("rst_cmp0_lo", dd, 32'hFFFF_FFFF);
        chk("rst_irq", irq, 2'b00);
        rd_chk("rst_ctrl", 16'hC000, 32'h1);
        rd_chk("rst_mtime", 16'hBFF8, 32'h0);

        // Out-of-range accesses and MSIP
        xfer(1'b1, 16'h000C, 32'h1, 4'hF, dd, ee);
        chk("msip3_err", ee, 1'b1);
        chk("msip3_rdata", dd, 32'h0);
        chk("msip3_ipi", ipi, 2'b00);
        xfer(1'b0, 16'hC008, 32'h0, 4'h0, dd, ee);
        chk("c008_err", ee, 1'b1);
        chk("c008_rdata", dd, 32'h0);
        wr(16'h0004, 32'h1, 4'h1);
        chk("msip1_ipi", ipi, 2'b10);
        wr(16'h0004, 32'h0, 4'h1);

        // Atomic LO/HI read across a carry
        wr(16'hC000, 32'h2, 4'h1);
        wr(16'hC004, 32'h3, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hC000, 32'h3, 4'h1);
        idle(2);
        rd_chk("pre_carry_lo", 16'hBFF8, 32'hFFFF_FFFF);
        idle(1);
        rd_chk("shadow_hi", 16'hBFFC, 32'h0);
        rd_chk("carry_lo", 16'hBFF8, 32'h0);
        rd_chk("carry_hi", 16'hBFFC, 32'h1);

        // Byte write colliding with a prescaler tick
        wr(16'hC004, 32'd20, 4'hF);
        wr(16'hBFF8, 32'h1122_3344, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        idle(18);
        wr(16'hBFF8, 32'h0000_00AB, 4'h1);
        chk("model_tick_collide", m_last_tick, 1'b1);
        rd_chk("be_write_lo", 16'hBFF8, 32'h1122_33AB);
        rd_chk("be_write_hi", 16'hBFFC, 32'h0);

        // Prescaled mtime against mtimecmp[1]
        wr(16'hC000, 32'h2, 4'h1);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'h4008, 32'h5, 4'hF);
        wr(16'h400C, 32'h0, 4'hF);
        wr(16'hC004, 32'h3, 4'hF);
        wr(16'hC000, 32'h3, 4'h1);
        idle(20);
        chk("irq_before", irq, 2'b00);
        chk("model_mtime5", m_mtime, 64'd5);
        idle(1);
        chk("irq_after", irq, 2'b10);
        rd_chk("mtime_at_irq", 16'hBFF8, 32'h5);

        // rtc source at 1/8 of clk
        wr(16'hC000, 32'h2, 4'h1);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hC000, 32'h1, 4'h1);
        rtc = 1'b1;
        idle(2);
        rd_chk("rtc_latency_old", 16'hBFF8, 32'h0);
        rd_chk("rtc_latency_new", 16'hBFF8, 32'h1);
        rtc = 1'b0;
        for (int p = 0; p < 4; p++) begin
            idle(4);
            rtc = 1'b1;
            idle(4);
            rtc = 1'b0;
        end
        idle(6);
        rd_chk("rtc_count", 16'hBFF8, 32'h5);

        // Randomised traffic, including resets that hit pending requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rtc = ~rtc;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) begin
                req   = 1'b1;
                we    = 1'($urandom_range(0, 1));
                addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                    : (addr_tab[$urandom_range(0, 17)] | 16'($urandom_range(0, 3)));
                wdata = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
                be    = 4'($urandom);
            end else begin
                req = 1'b0;
                we  = 1'b0;
            end
            @(negedge clk);
        end
        req = 1'b0; we = 1'b0; rst = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
